alu_result_queue: RTL and testbench

ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

---
 rtl/alu_result_queue.sv | 108 ++++++++++
 tb/tb_alu_result_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// ALU result queue: selects one of three unit results (or repeats the last one)
// and buffers it with zero/negative flags in a small FIFO for a downstream consumer.
module alu_result_queue #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [N-1:0]     RA,
  input  logic signed [N-1:0]     RL,
  input  logic signed [N-1:0]     RS,
  input  logic                    s1,
  input  logic                    s0,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [N-1:0]     RC,
  output logic                    zf,
  output logic                    nf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] Full = (AW+1)'(DEPTH);

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic signed [N-1:0] last_q, last_d;

  logic signed [N-1:0] val_mem [DEPTH];
  logic                zf_mem  [DEPTH];
  logic                nf_mem  [DEPTH];

  logic                push, pop;
  logic [1:0]          sel;
  logic signed [N-1:0] sel_val;

  assign sel       = {s1, s0};
  assign count     = count_q;
  assign in_ready  = (count_q < Full);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    sel_val = last_q;
    case (sel)
      2'b00:   sel_val = RA;
      2'b01:   sel_val = RL;
      2'b11:   sel_val = RS;
      default: sel_val = last_q;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (sel != 2'b10) last_d = sel_val;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage is not cleared; the output mux hides stale entries when empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      val_mem[wr_ptr_q] <= sel_val;
      zf_mem[wr_ptr_q]  <= (sel_val == '0);
      nf_mem[wr_ptr_q]  <= sel_val[N-1];
    end
  end

  always_comb begin
    RC = '0;
    zf = 1'b1;
    nf = 1'b0;
    if (out_valid) begin
      RC = val_mem[rd_ptr_q];
      zf = zf_mem[rd_ptr_q];
      nf = nf_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_alu_result_queue;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic signed [N-1:0]    RA, RL, RS;
  logic                   s1, s0;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [N-1:0]    RC;
  logic                   zf, nf;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] model_q [$];
  logic [N-1:0] model_last;

  alu_result_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .RA        (RA),
    .RL        (RL),
    .RS        (RS),
    .s1        (s1),
    .s0        (s0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RC        (RC),
    .zf        (zf),
    .nf        (nf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned sz;
    logic [N-1:0] head;
    sz   = model_q.size();
    head = (sz != 0) ? model_q[0] : '0;
    check({tag, ".count"},     32'(count), sz);
    check({tag, ".in_ready"},  32'(in_ready), 32'(sz < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
    check({tag, ".RC"},        32'($unsigned(RC)), 32'(head));
    check({tag, ".zf"},        32'(zf), 32'(head == '0));
    check({tag, ".nf"},        32'(nf), 32'(head[N-1]));
  endtask

  // Reference behaviour from the queue's rules: reset clears, pop then push by capacity.
  task automatic model_step();
    logic [N-1:0] v;
    logic         do_push, do_pop;
    if (rst) begin
      model_q.delete();
      model_last = '0;
      return;
    end
    do_push = in_valid && (model_q.size() < DEPTH);
    do_pop  = out_ready && (model_q.size() != 0);
    case ({s1, s0})
      2'b00:   v = RA;
      2'b01:   v = RL;
      2'b11:   v = RS;
      default: v = model_last;
    endcase
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      model_q.push_back(v);
      if ({s1, s0} != 2'b10) model_last = v;
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] sel, input logic [N-1:0] a,
                       input logic [N-1:0] l, input logic [N-1:0] s,
                       input logic iv, input logic ordy, input string tag);
    rst       = r;
    {s1, s0}  = sel;
    RA        = a;
    RL        = l;
    RS        = s;
    in_valid  = iv;
    out_ready = ordy;
    @(negedge clk);
    check_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; {s1, s0} = 2'b00; RA = '0; RL = '0; RS = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_q.delete();
    model_last = '0;

    cycle(1'b1, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "reset");
    check("reset.count", 32'(count), 0);
    check("reset.zf", 32'(zf), 1);

    // Single arithmetic push, latency 1
    cycle(1'b0, 2'b00, 8'sd5, 8'd0, 8'd0, 1'b1, 1'b0, "r31_push");
    check("r31.RC", 32'($unsigned(RC)), 5);
    check("r31.count", 32'(count), 1);
    check("r31.zf", 32'(zf), 0);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "r31_pop");

    // Logic push of 0x80 then repeat-last
    cycle(1'b0, 2'b01, 8'd0, 8'h80, 8'd0, 1'b1, 1'b0, "r32_push_l");
    cycle(1'b0, 2'b10, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, "r32_push_rep");
    check("r32.count", 32'(count), 2);
    check("r32.RC", 32'($unsigned(RC)), 32'h80);
    check("r32.nf", 32'(nf), 1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "r32_pop0");
    check("r32.RC2", 32'($unsigned(RC)), 32'h80);
    check("r32.nf2", 32'(nf), 1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "r32_pop1");

    // Shifter zero result
    cycle(1'b0, 2'b11, 8'd7, 8'd9, 8'd0, 1'b1, 1'b0, "r33_push");
    check("r33.zf", 32'(zf), 1);
    check("r33.out_valid", 32'(out_valid), 1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "r33_pop");
    check("r33.empty_valid", 32'(out_valid), 0);
    check("r33.empty_zf", 32'(zf), 1);

    // Overfill: fifth push dropped
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 2'b00, 8'(10 + i), 8'd0, 8'd0, 1'b1, 1'b0, "r34_push");
    check("r34.count", 32'(count), 4);
    check("r34.in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      check("r34.order", 32'($unsigned(RC)), 32'(10 + i));
      cycle(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "r34_pop");
    end
    check("r34.drained", 32'(out_valid), 0);

    // Steady push+pop across pointer wrap
    cycle(1'b0, 2'b00, 8'd20, 8'd0, 8'd0, 1'b1, 1'b0, "r35_fill");
    cycle(1'b0, 2'b00, 8'd21, 8'd0, 8'd0, 1'b1, 1'b0, "r35_fill");
    for (int i = 0; i < 10; i++) begin
      check("r35.head", 32'($unsigned(RC)), 32'(20 + i));
      cycle(1'b0, 2'b00, 8'(22 + i), 8'd0, 8'd0, 1'b1, 1'b1, "r35_stream");
      check("r35.count", 32'(count), 2);
    end
    repeat (2) cycle(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "r35_drain");

    // Reset beats a concurrent push/pop and clears last_result
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 2'b01, 8'd0, 8'(40 + i), 8'd0, 1'b1, 1'b0, "r36_fill");
    cycle(1'b1, 2'b00, 8'd99, 8'd0, 8'd0, 1'b1, 1'b1, "r36_rst");
    check("r36.count", 32'(count), 0);
    check("r36.out_valid", 32'(out_valid), 0);
    cycle(1'b0, 2'b10, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0, "r36_rep");
    check("r36.RC", 32'($unsigned(RC)), 0);
    check("r36.valid", 32'(out_valid), 1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "r36_pop");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
